// File: rtl/md_array_seq_ctrl.sv
// Operand/result register stage and settle-time sequencer around the
// combinational modular multiply/divide cell array.
module md_array_seq_ctrl #(
  parameter int N      = 4,
  parameter int SETTLE = 2
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic           MUL_BAR_IN,
  input  logic [2*N-1:0] OPA_IN,
  input  logic [N-1:0]   OPB_IN,
  output logic [2*N-1:0] ARR_X,
  output logic [N-1:0]   ARR_Y,
  output logic           ARR_MUL_BAR,
  input  logic [N-1:0]   ARR_RES_HI,
  input  logic [N-1:0]   ARR_RES_LO,
  output logic           BUSY,
  output logic           DONE,
  output logic [N-1:0]   RESULT_HI,
  output logic [N-1:0]   RESULT_LO,
  output logic           DIV_ERR
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          div_err;
  logic          accept;

  // Quotient must fit in N bits, so the dividend's upper half must be below the divisor.
  assign div_err = MUL_BAR_IN && ((OPB_IN == '0) || (OPA_IN[2*N-1:N] >= OPB_IN));

  always_ff @(posedge CLK) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    BUSY     = 1'b0;
    DONE     = 1'b0;
    case (state)
      S_IDLE: begin
        accept = START;
        if (START) state_nx = div_err ? S_DONE : S_WAIT;
      end
      S_WAIT: begin
        BUSY = 1'b1;
        if (cnt == '0) state_nx = S_DONE;
      end
      S_DONE: begin
        DONE     = 1'b1;
        accept   = START;
        state_nx = START ? (div_err ? S_DONE : S_WAIT) : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      ARR_X       <= '0;
      ARR_Y       <= '0;
      ARR_MUL_BAR <= 1'b0;
      RESULT_HI   <= '0;
      RESULT_LO   <= '0;
      DIV_ERR     <= 1'b0;
      cnt         <= '0;
    end else if (accept) begin
      if (div_err) begin
        // Screened out: the array never sees this operation.
        RESULT_HI <= '0;
        RESULT_LO <= '0;
        DIV_ERR   <= 1'b1;
      end else begin
        ARR_MUL_BAR <= MUL_BAR_IN;
        ARR_Y       <= OPB_IN;
        ARR_X       <= MUL_BAR_IN ? OPA_IN : {{N{1'b0}}, OPA_IN[N-1:0]};
        cnt         <= CW'(SETTLE - 1);
      end
    end else if (state == S_WAIT) begin
      if (cnt == '0) begin
        RESULT_HI <= ARR_RES_HI;
        RESULT_LO <= ARR_RES_LO;
        DIV_ERR   <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md_array_seq_ctrl.sv
// Directed bench for md_array_seq_ctrl with a behavioural mul/div array model.
module tb_md_array_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST, START, MUL_BAR_IN;
  logic [7:0] OPA_IN;
  logic [3:0] OPB_IN;
  logic [7:0] ARR_X;
  logic [3:0] ARR_Y;
  logic       ARR_MUL_BAR;
  logic [3:0] ARR_RES_HI, ARR_RES_LO;
  logic       BUSY, DONE, DIV_ERR;
  logic [3:0] RESULT_HI, RESULT_LO;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  md_array_seq_ctrl #(.N(4), .SETTLE(2)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MUL_BAR_IN(MUL_BAR_IN),
    .OPA_IN(OPA_IN), .OPB_IN(OPB_IN), .ARR_X(ARR_X), .ARR_Y(ARR_Y),
    .ARR_MUL_BAR(ARR_MUL_BAR), .ARR_RES_HI(ARR_RES_HI), .ARR_RES_LO(ARR_RES_LO),
    .BUSY(BUSY), .DONE(DONE), .RESULT_HI(RESULT_HI), .RESULT_LO(RESULT_LO),
    .DIV_ERR(DIV_ERR)
  );

  // Behavioural array: 4x4 multiply or 8/4 divide.
  logic [7:0] prod;
  always_comb begin
    prod       = ARR_X[3:0] * ARR_Y;
    ARR_RES_HI = prod[7:4];
    ARR_RES_LO = prod[3:0];
    if (ARR_MUL_BAR && ARR_Y != 0) begin
      ARR_RES_LO = 4'(ARR_X / {4'h0, ARR_Y});
      ARR_RES_HI = 4'(ARR_X % {4'h0, ARR_Y});
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 0; START = 0; MUL_BAR_IN = 0; OPA_IN = 0; OPB_IN = 0;
    step(); step();
    n_cmp++; if (ARR_X !== 8'h00) begin n_err++; $display("FAIL reset_arr_x: got %h want 00", ARR_X); end
    n_cmp++; if ({ARR_Y, ARR_MUL_BAR} !== 5'h0) begin n_err++; $display("FAIL reset_arr_y_mb: got %h want 00", {ARR_Y, ARR_MUL_BAR}); end
    n_cmp++; if ({RESULT_HI, RESULT_LO, DIV_ERR} !== 9'h0) begin n_err++; $display("FAIL reset_result: got %h want 000", {RESULT_HI, RESULT_LO, DIV_ERR}); end
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_err++; $display("FAIL reset_busy_done: got %b want 00", {BUSY, DONE}); end
    RST = 1;
    step();
  endtask

  task automatic test_mul();
    MUL_BAR_IN = 0; OPA_IN = 8'hF5; OPB_IN = 4'h3; START = 1;
    step(); START = 0;                                      // cycle 1
    n_cmp++; if ({ARR_X, ARR_Y, ARR_MUL_BAR} !== {8'h05, 4'h3, 1'b0}) begin n_err++; $display("FAIL mul_arr: got %h/%h/%b want 05/3/0", ARR_X, ARR_Y, ARR_MUL_BAR); end
    n_cmp++; if ({BUSY, DONE} !== 2'b10) begin n_err++; $display("FAIL mul_c1_bd: got %b want 10", {BUSY, DONE}); end
    step();                                                 // cycle 2
    n_cmp++; if ({BUSY, DONE} !== 2'b10) begin n_err++; $display("FAIL mul_c2_bd: got %b want 10", {BUSY, DONE}); end
    step();                                                 // cycle 3
    n_cmp++; if ({BUSY, DONE} !== 2'b01) begin n_err++; $display("FAIL mul_c3_bd: got %b want 01", {BUSY, DONE}); end
    n_cmp++; if ({RESULT_HI, RESULT_LO, DIV_ERR} !== {4'h0, 4'hF, 1'b0}) begin n_err++; $display("FAIL mul_result: got %h/%h/%b want 0/f/0", RESULT_HI, RESULT_LO, DIV_ERR); end
    step();                                                 // cycle 4
    n_cmp++; if ({BUSY, DONE} !== 2'b00) begin n_err++; $display("FAIL mul_c4_bd: got %b want 00", {BUSY, DONE}); end
  endtask

  task automatic test_div();
    MUL_BAR_IN = 1; OPA_IN = 8'h2B; OPB_IN = 4'h5; START = 1;
    step(); START = 0;
    n_cmp++; if ({ARR_X, ARR_Y, ARR_MUL_BAR} !== {8'h2B, 4'h5, 1'b1}) begin n_err++; $display("FAIL div_arr: got %h/%h/%b want 2b/5/1", ARR_X, ARR_Y, ARR_MUL_BAR); end
    step();
    n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL div_c2_done: got %b want 0", DONE); end
    step();
    n_cmp++; if (DONE !== 1'b1) begin n_err++; $display("FAIL div_c3_done: got %b want 1", DONE); end
    n_cmp++; if ({RESULT_HI, RESULT_LO, DIV_ERR} !== {4'h3, 4'h8, 1'b0}) begin n_err++; $display("FAIL div_result: got %h/%h/%b want 3/8/0", RESULT_HI, RESULT_LO, DIV_ERR); end
    step();
  endtask

  task automatic test_hold();
    int done_seen = 0;
    MUL_BAR_IN = 0; OPA_IN = 8'hFF; OPB_IN = 4'h1; START = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (DONE) done_seen++;
    end
    n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL hold_done: got %0d pulses want 0", done_seen); end
    n_cmp++; if ({RESULT_HI, RESULT_LO, DIV_ERR} !== {4'h3, 4'h8, 1'b0}) begin n_err++; $display("FAIL hold_result: got %h/%h/%b want 3/8/0", RESULT_HI, RESULT_LO, DIV_ERR); end
    n_cmp++; if ({ARR_X, ARR_Y, ARR_MUL_BAR} !== {8'h2B, 4'h5, 1'b1}) begin n_err++; $display("FAIL hold_arr: got %h/%h/%b want 2b/5/1", ARR_X, ARR_Y, ARR_MUL_BAR); end
  endtask

  task automatic test_div_err(input logic [7:0] a, input logic [3:0] b, input string nm);
    MUL_BAR_IN = 1; OPA_IN = a; OPB_IN = b; START = 1;
    step(); START = 0;                                      // cycle 1
    n_cmp++; if ({BUSY, DONE, DIV_ERR} !== 3'b011) begin n_err++; $display("FAIL %s_flags: got bd_err=%b want 011", nm, {BUSY, DONE, DIV_ERR}); end
    n_cmp++; if ({RESULT_HI, RESULT_LO} !== 8'h00) begin n_err++; $display("FAIL %s_result: got %h want 00", nm, {RESULT_HI, RESULT_LO}); end
    n_cmp++; if ({ARR_X, ARR_Y, ARR_MUL_BAR} !== {8'h2B, 4'h5, 1'b1}) begin n_err++; $display("FAIL %s_arr: got %h/%h/%b want 2b/5/1", nm, ARR_X, ARR_Y, ARR_MUL_BAR); end
    step();                                                 // cycle 2
    n_cmp++; if ({BUSY, DONE, DIV_ERR} !== 3'b001) begin n_err++; $display("FAIL %s_after: got bd_err=%b want 001", nm, {BUSY, DONE, DIV_ERR}); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_bd [0:7];
    exp_bd = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b00};
    MUL_BAR_IN = 0; OPA_IN = 8'h03; OPB_IN = 4'h3; START = 1;
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 3) OPB_IN = 4'h3;
      if (c == 6) START = 0;
      n_cmp++; if ({BUSY, DONE} !== exp_bd[c]) begin n_err++; $display("FAIL b2b_c%0d_bd: got %b want %b", c, {BUSY, DONE}, exp_bd[c]); end
      if (c == 6) begin
        n_cmp++; if ({RESULT_HI, RESULT_LO} !== 8'h09) begin n_err++; $display("FAIL b2b_result: got %h want 09", {RESULT_HI, RESULT_LO}); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int done_seen = 0;
    MUL_BAR_IN = 0; OPA_IN = 8'hF5; OPB_IN = 4'h3; START = 1;
    step(); START = 0;                                      // cycle 1
    step(); RST = 0;                                        // cycle 2
    step(); RST = 1;                                        // cycle 3
    n_cmp++; if ({ARR_X, ARR_Y, ARR_MUL_BAR} !== 13'h0) begin n_err++; $display("FAIL rstmid_arr: got %h/%h/%b want 0", ARR_X, ARR_Y, ARR_MUL_BAR); end
    n_cmp++; if ({BUSY, DONE, RESULT_HI, RESULT_LO, DIV_ERR} !== 11'h0) begin n_err++; $display("FAIL rstmid_out: got %b want 0", {BUSY, DONE, RESULT_HI, RESULT_LO, DIV_ERR}); end
    for (int i = 0; i < 4; i++) begin
      if (DONE) done_seen++;
      step();
    end
    n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL rstmid_done: got %0d pulses want 0", done_seen); end
    test_mul();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_hold();
    test_div_err(8'h10, 4'h0, "div0");
    test_div_err(8'h50, 4'h5, "divovf");
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/md_array_seq_ctrl.md
Name: md_array_seq_ctrl

Overview:
Sequencing and operand/result register stage that sits directly upstream and downstream of the combinational modular multiply/divide cell array.
- Accepts a START-qualified operation, registers the operands and the MUL_BAR mode onto the array inputs, and waits a fixed settle time.
- Captures the array's product, or its quotient/remainder, and presents it with a one-cycle DONE pulse.
- Screens divide-by-zero and quotient overflow without using the array.

Parameters:
N, 4, operand width. Product is 2N; dividend is 2N; divisor, quotient and remainder are N.
SETTLE, 2, cycles the array inputs are held stable before capture. Legal values are 1 and above.

Ports:
CLK  input  1  clock; all logic on the rising edge.
RST  input  1  synchronous, active-low reset.
START  input  1  operation request; sampled only in IDLE or DONE.
MUL_BAR_IN  input  1  operation select: 0 = multiply, 1 = divide.
OPA_IN  input  2N  multiply: multiplicand in [N-1:0], [2N-1:N] ignored. Divide: dividend.
OPB_IN  input  N  multiplier or divisor.
ARR_X  output  2N  registered array X operand.
ARR_Y  output  N  registered array Y operand.
ARR_MUL_BAR  output  1  registered array mode.
ARR_RES_HI  input  N  array result, upper half (product high / remainder).
ARR_RES_LO  input  N  array result, lower half (product low / quotient).
BUSY  output  1  high while an operation is in flight.
DONE  output  1  one-cycle pulse: result valid.
RESULT_HI  output  N  captured product high or remainder.
RESULT_LO  output  N  captured product low or quotient.
DIV_ERR  output  1  divide error flag, held with the result.

Behaviour:
- Reset (RST=0 at a clock edge):
  - State goes to IDLE.
  - ARR_X, ARR_Y, ARR_MUL_BAR, RESULT_HI, RESULT_LO, DIV_ERR, BUSY and DONE all go to 0.
  - Reset has priority over every other event, including START.
  - Reset mid-WAIT aborts the operation; no DONE is ever produced for it.
- States: IDLE, WAIT, DONE.
- IDLE (BUSY=0, DONE=0). When START=1 at an edge, the error check is evaluated on the inputs:
  - Divide error condition: MUL_BAR_IN=1 and either OPB_IN==0 or OPA_IN[2N-1:N] >= OPB_IN.
  - On divide error: go to DONE with DIV_ERR=1 and RESULT_HI/LO=0. ARR_* registers are not updated.
  - Otherwise, load the array registers:
    - ARR_MUL_BAR <= MUL_BAR_IN.
    - ARR_Y <= OPB_IN.
    - ARR_X <= OPA_IN for divide; ARR_X <= {N'b0, OPA_IN[N-1:0]} for multiply.
    - Settle counter <= SETTLE-1; go to WAIT.
- WAIT (BUSY=1):
  - ARR_* are held constant; START is ignored.
  - The counter decrements each cycle.
  - At the edge where the counter is 0: RESULT_HI <= ARR_RES_HI, RESULT_LO <= ARR_RES_LO, DIV_ERR <= 0; go to DONE.
- DONE (DONE=1, BUSY=0), lasts exactly one cycle:
  - START is accepted exactly as in IDLE, giving back-to-back operations.
  - Otherwise go to IDLE.
- Latency, with START sampled at the end of cycle 0:
  - Normal operation: ARR_* are valid from cycle 1, ARR_RES is sampled at the end of cycle SETTLE, and DONE is high in cycle SETTLE+1.
  - Error path: DONE is high in cycle 1.
- RESULT_HI, RESULT_LO and DIV_ERR hold their values until the next DONE or reset.
- ARR_* hold the last accepted operands while idle.
- The counter is wide enough for SETTLE-1. There is no wrap-around because the counter is reloaded on every accept.
- Results are taken from the array verbatim; no sign handling (unsigned only).

Test Plan:
All scenarios use N=4, SETTLE=2, and a bench behavioural array model.
1. Multiply: MUL_BAR_IN=0, OPA_IN=8'hF5, OPB_IN=4'h3, START in cycle 0 -> ARR_X=8'h05, ARR_Y=4'h3, ARR_MUL_BAR=0 from cycle 1; BUSY in cycles 1-2; DONE in cycle 3 only; RESULT_HI=4'h0, RESULT_LO=4'hF, DIV_ERR=0.
2. Divide: MUL_BAR_IN=1, OPA_IN=8'h2B, OPB_IN=4'h5 -> ARR_X=8'h2B; DONE in cycle 3; RESULT_LO=4'h8 (quotient), RESULT_HI=4'h3 (remainder), DIV_ERR=0.
3. Divide error: OPA_IN=8'h10 with OPB_IN=0, then OPA_IN=8'h50 with OPB_IN=4'h5 -> each gives DONE in cycle 1, DIV_ERR=1, RESULT_HI/LO=0, BUSY never high, ARR_* unchanged.
4. Busy/back-to-back: START held high in cycles 0-5 with 3x3 -> the START pulses in cycles 1-2 are ignored; a new operation is accepted in the DONE cycle (3); second DONE in cycle 6 with RESULT_LO=4'h9.
5. Reset mid-operation: START in cycle 0, RST=0 during cycle 2 -> all outputs 0 from cycle 3; no DONE; next START behaves exactly as in scenario 1.
6. Hold: after scenario 2, inputs change and START stays 0 for 10 cycles -> RESULT_HI/LO, DIV_ERR and ARR_* remain unchanged; DONE stays 0.
